// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed hex display scanner with dead-time blanking,
// tear-free frame buffering and optional leading-zero suppression.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   digit_an,
    output logic                    frame_pulse
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DW-1:0]         pending, disp, disp_nxt;
    logic                  pend_v;
    logic                  slot_end, frame_end;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            sel_nib;
    logic                  sel_blank;
    logic                  lit_nxt;
    logic [3:0]            nibble_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        slot_end  = enable && (cnt == CW'(PRESCALE - 1));
        frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        disp_nxt  = disp;
        if (enable) begin
            if (slot_end) begin
                cnt_nxt = '0;
                idx_nxt = frame_end ? '0 : idx + 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        // The frame swap uses the pending value held before this edge's load.
        if (frame_end && pend_v) begin
            disp_nxt = pending;
        end
    end

    // lz_blank[k] marks digit k as a leading zero of the value about to be shown.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above  = zero_above && (disp_nxt[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_above && (k != 0);
        end
    end

    // Outputs are derived from the next state so the registered bus matches cnt/idx.
    always_comb begin
        sel_nib   = 4'h0;
        sel_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                sel_nib   = disp_nxt[4*k +: 4];
                sel_blank = lz_blank[k];
            end
        end
        lit_nxt    = enable && (32'(cnt_nxt) >= 32'(BLANK_CYCLES)) && !(blank_lz && sel_blank);
        an_nxt     = lit_nxt ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
        nibble_nxt = lit_nxt ? sel_nib : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            pending     <= '0;
            pend_v      <= 1'b0;
            disp        <= '0;
            nibble      <= 4'h0;
            digit_an    <= '1;
            frame_pulse <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            disp        <= disp_nxt;
            if (load) begin
                pending <= value;
                pend_v  <= 1'b1;
            end else if (frame_end) begin
                pend_v  <= 1'b0;
            end
            frame_pulse <= frame_end;
            digit_an    <= an_nxt;
            nibble      <= nibble_nxt;
        end
    end

endmodule
